// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: RV64 widths, base opcodes shared with decode/ImmGen, fetch FSM states
package inst_fetch_pkg;
   localparam int XLEN = 64;
   localparam int INST_W = 32;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t FETCH = 2'd0;
   localparam fetch_state_t WAIT = 2'd1;
   localparam fetch_state_t DROP = 2'd2;
endpackage

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: DEPTH-entry FIFO of fetched {pc, inst} pairs with flush
module inst_fetch_buffer
   import inst_fetch_pkg::*;
#(
   parameter int PC_W = 64,
   parameter int DEPTH = 2
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [PC_W-1:0]        pc_i,
   input  logic [INST_W-1:0]      inst_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic [PC_W-1:0]        pc_o,
   output logic [INST_W-1:0]      inst_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o,
   output logic                   full_o
);
   localparam int AW = $clog2(DEPTH);
   logic [PC_W-1:0] pc_q [DEPTH];
   logic [INST_W-1:0] inst_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [AW:0] count_q;
   assign empty_o = count_q == '0;
   assign full_o = count_q == (AW+1)'(DEPTH);
   assign count_o = count_q;
   assign pc_o = pc_q[rd_q];
   assign inst_o = inst_q[rd_q];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q <= '0;
         wr_q <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         rd_q <= '0;
         wr_q <= '0;
         count_q <= '0;
      end else begin
         rd_q <= rd_q + AW'(pop_i);
         wr_q <= wr_q + AW'(push_i);
         count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      end
   end
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) begin
         pc_q[wr_q] <= pc_i;
         inst_q[wr_q] <= inst_i;
      end
   end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, issues one-outstanding imem reads and buffers words for decode
module inst_fetch #(
   parameter int XLEN = inst_fetch_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int BUF_DEPTH = 2
)(
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready
);
   import inst_fetch_pkg::*;
   localparam int CW = $clog2(BUF_DEPTH) + 1;
   fetch_state_t state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, tag_q, tag_d, buf_pc;
   logic [INST_W-1:0] buf_inst;
   logic [CW-1:0] buf_count;
   logic buf_empty, buf_full, busy, push, pop;
   assign busy = state_q != FETCH;
   // outstanding is implied by busy, so gating on count alone keeps count+outstanding <= depth
   assign imem_req = rst_n && !busy && !redirect_valid && (32'(buf_count) < BUF_DEPTH);
   assign imem_addr = imem_req ? pc_q : '0;
   assign push = state_q == WAIT && imem_rvalid && !redirect_valid && !buf_full;
   assign inst_valid = !buf_empty;
   assign pop = inst_valid && inst_ready && !redirect_valid;
   assign inst = inst_valid ? buf_inst : '0;
   assign inst_pc = inst_valid ? buf_pc : '0;
   always_comb begin
      pc_d = redirect_valid ? (redirect_pc & ~XLEN'(3)) : imem_req ? pc_q + XLEN'(4) : pc_q;
      tag_d = imem_req ? pc_q : tag_q;
      state_d = redirect_valid ? ((busy && !imem_rvalid) ? DROP : FETCH)
              : imem_req ? WAIT : (busy && imem_rvalid) ? FETCH : state_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q <= RESET_PC;
         tag_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         tag_q <= tag_d;
      end
   end
   inst_fetch_buffer #(.PC_W(XLEN), .DEPTH(BUF_DEPTH)) u_buf (
      .clk(clk),
      .rst_n(rst_n),
      .push_i(push),
      .pc_i(tag_q),
      .inst_i(imem_rdata),
      .pop_i(pop),
      .flush_i(redirect_valid),
      .pc_o(buf_pc),
      .inst_o(buf_inst),
      .count_o(buf_count),
      .empty_o(buf_empty),
      .full_o(buf_full)
   );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: random memory/decode/redirect traffic scored against the sequential-PC stream model
module tb_inst_fetch;
   logic clk = 0;
   logic rst_n, imem_req, imem_rvalid, redirect_valid, inst_valid, inst_ready;
   logic [63:0] imem_addr, redirect_pc, inst_pc;
   logic [31:0] imem_rdata, inst;
   typedef struct {logic [63:0] pc; logic [31:0] w;} ent_t;
   ent_t exp_q[$];
   logic [63:0] req_log[$];
   int n_cmp = 0, n_bad = 0, n_req = 0, n_pop = 0;
   int ready_pct = 100, redir_pct = 0, lat_min = 1, lat_max = 1, mem_lat = 0;
   bit mem_busy = 0, f_redir = 0;
   logic [63:0] mem_addr = '0, f_pc = '0, exp_fetch = '0, stream_pc = '0;

   inst_fetch dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [63:0] m;
      m = (a ^ 64'h5DEECE66D) * 64'h9E3779B97F4A7C15;
      return m[54:23];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // decode must see every word from the restart point onward in address order
   task automatic refill();
      while (exp_q.size() < 32) begin
         exp_q.push_back('{stream_pc, mem_word(stream_pc)});
         stream_pc += 64'd4;
      end
   endtask

   task automatic restart(input logic [63:0] t);
      exp_fetch = {t[63:2], 2'b00};
      stream_pc = exp_fetch;
      exp_q.delete();
      refill();
   endtask

   task automatic cycle();
      bit was_busy;
      @(negedge clk);
      was_busy = mem_busy;
      imem_rvalid = 0;
      if (mem_busy) begin
         if (mem_lat <= 1) begin
            imem_rvalid = 1;
            imem_rdata = mem_word(mem_addr);
            mem_busy = 0;
         end else mem_lat--;
      end
      inst_ready = $urandom_range(0, 99) < ready_pct;
      redirect_valid = f_redir || (rst_n && $urandom_range(0, 99) < redir_pct);
      if (redirect_valid) begin
         redirect_pc = f_redir ? f_pc : 64'($urandom_range(0, 65535));
         restart(redirect_pc);
      end
      f_redir = 0;
      #1;
      if (rst_n && imem_req) begin
         chk("req_while_outstanding", 64'(was_busy), 0);
         chk("imem_addr", imem_addr, exp_fetch);
         exp_fetch += 64'd4;
         n_req++;
         req_log.push_back(imem_addr);
         mem_busy = 1;
         mem_lat = $urandom_range(lat_min, lat_max);
         mem_addr = imem_addr;
      end
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #2;
      rst_n = 0;
      mem_busy = 0;
      imem_rvalid = 0;
      redirect_valid = 0;
      inst_ready = 0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1;
      restart(64'h0);
      n_req = 0;
      req_log.delete();
   endtask

   initial begin
      bit hold;
      logic [63:0] h_pc;
      logic [31:0] h_w;
      ent_t e;
      hold = 0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) hold = 0;
         else begin
            if (hold) begin
               chk("hold_valid", 64'(inst_valid), 1);
               chk("hold_pc", inst_pc, h_pc);
               chk("hold_inst", 64'(inst), 64'(h_w));
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
               n_pop++;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL pop_unexpected: got pc %h, expected no delivery", inst_pc);
               end else begin
                  e = exp_q.pop_front();
                  chk("inst_pc", inst_pc, e.pc);
                  chk("inst", 64'(inst), 64'(e.w));
                  refill();
               end
            end
            hold = inst_valid && !inst_ready && !redirect_valid;
            h_pc = inst_pc;
            h_w = inst;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish, expected finish before 500000");
      $fatal(1, "timeout");
   end

   initial begin
      int n0;
      rst_n = 1;
      imem_rvalid = 0;
      imem_rdata = '0;
      redirect_valid = 0;
      redirect_pc = '0;
      inst_ready = 0;
      #1 rst_n = 0;
      #1;
      chk("rst_req", 64'(imem_req), 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_valid", 64'(inst_valid), 0);
      chk("rst_inst", 64'(inst), 0);
      chk("rst_pc", inst_pc, 0);
      // sequential fetch, latency 1
      reset_dut();
      repeat (6) cycle();
      chk("t1_reqs", 64'(n_req), 3);
      chk("t1_third", req_log.size() > 2 ? req_log[2] : 'x, 64'h8);
      repeat (4) cycle();
      // decode stalled: buffer fills, fetch stops
      reset_dut();
      ready_pct = 0;
      repeat (10) cycle();
      chk("t2_reqs", 64'(n_req), 2);
      chk("t2_valid", 64'(inst_valid), 1);
      chk("t2_pc", inst_pc, 0);
      chk("t2_inst", 64'(inst), 64'(mem_word(0)));
      ready_pct = 100;
      repeat (6) cycle();
      chk("t2_resume", req_log.size() > 2 ? req_log[2] : 'x, 64'h8);
      // redirect while waiting on 0x10
      reset_dut();
      lat_min = 3;
      lat_max = 3;
      for (int i = 0; i < 200 && !(req_log.size() > 0 && req_log[req_log.size()-1] == 64'h10); i++) cycle();
      f_redir = 1;
      f_pc = 64'h1003;
      cycle();
      n0 = n_req;
      for (int i = 0; i < 30 && n_req == n0; i++) cycle();
      chk("t3_addr", req_log.size() > 0 ? req_log[req_log.size()-1] : 'x, 64'h1000);
      repeat (10) cycle();
      // redirect coinciding with rvalid and inst_ready
      reset_dut();
      lat_min = 1;
      lat_max = 1;
      ready_pct = 0;
      for (int i = 0; i < 20 && n_req < 2; i++) cycle();
      ready_pct = 100;
      f_redir = 1;
      f_pc = 64'h2000;
      cycle();
      cycle();
      chk("t4_empty", 64'(inst_valid), 0);
      chk("t4_req", 64'(imem_req), 1);
      chk("t4_addr", imem_addr, 64'h2000);
      repeat (6) cycle();
      // address wrap
      req_log.delete();
      f_redir = 1;
      f_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      cycle();
      repeat (6) cycle();
      chk("t5_top", req_log.size() > 0 ? req_log[0] : 'x, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("t5_wrap", req_log.size() > 1 ? req_log[1] : 'x, 64'h0);
      // async reset mid-wait with a buffered word
      reset_dut();
      lat_min = 3;
      lat_max = 3;
      ready_pct = 0;
      for (int i = 0; i < 30 && n_req < 2; i++) cycle();
      @(posedge clk);
      #3;
      rst_n = 0;
      mem_busy = 0;
      imem_rvalid = 0;
      redirect_valid = 0;
      #1;
      chk("t6_req", 64'(imem_req), 0);
      chk("t6_addr", imem_addr, 0);
      chk("t6_valid", 64'(inst_valid), 0);
      chk("t6_inst", 64'(inst), 0);
      chk("t6_pc", inst_pc, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1;
      restart(64'h0);
      req_log.delete();
      ready_pct = 100;
      repeat (4) cycle();
      chk("t6_first", req_log.size() > 0 ? req_log[0] : 'x, 64'h0);
      // random traffic
      reset_dut();
      ready_pct = 70;
      redir_pct = 4;
      lat_min = 1;
      lat_max = 4;
      repeat (3000) cycle();
      ready_pct = 100;
      redir_pct = 0;
      repeat (20) cycle();
      chk("delivered_enough", 64'(n_pop > 300), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
